// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared constants for the multi-cycle MIPS main controller. It holds the
//   opcode values, the 4-bit FSM state encoding, the PC / ALU-B / ALU-op
//   select codes and the opcode-class bundle produced by main_ctrl_decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_I_EXEC   = 4'd5,
    S_I_WB     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] ALU_SRC_B_RT    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  typedef struct packed {
    logic is_r;
    logic is_mem;
    logic is_lw;
    logic is_br;
    logic is_bne;
    logic is_j;
    logic is_jal;
    logic is_imm;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/main_ctrl_decode.sv
// main_ctrl_decode
//   Combinational opcode classifier for the main controller.
//   Ports:
//     opcode  in  6  latched instruction opcode
//     cls     out    opcode class flags (op_class_t); illegal set for any
//                    opcode the core does not implement
module main_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: cls.is_r = 1'b1;
      OP_LW: begin
        cls.is_mem = 1'b1;
        cls.is_lw  = 1'b1;
      end
      OP_SW:  cls.is_mem = 1'b1;
      OP_BEQ: cls.is_br  = 1'b1;
      OP_BNE: begin
        cls.is_br  = 1'b1;
        cls.is_bne = 1'b1;
      end
      OP_J:   cls.is_j = 1'b1;
      OP_JAL: begin
        cls.is_j   = 1'b1;
        cls.is_jal = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: cls.is_imm = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller
//   Multi-cycle main control FSM of the 32-bit MIPS core. Steps each
//   instruction through fetch / decode / execute / memory / writeback and
//   drives the datapath strobes.
//   Ports:
//     clk, rst_n (async, active-low)
//     opcode     instr[31:26], captured when ir_write_o=1
//     mem_ready  memory handshake, only looked at in FETCH / MEM_RD / MEM_WR
//     jr         jr flag from the R-type controller, only looked at in R_EXEC
//     *_o        datapath strobes and selects (see port list)
module multicycle_main_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       jr,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic [1:0] pc_src_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       rtype_o,
  output logic       reg_write_o,
  output logic       reg_write2_o,
  output logic       mem_to_reg_o,
  output logic       link_o,
  output logic       illegal_o
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  op_class_t  cls;

  main_ctrl_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    pc_src_o     = PC_SRC_PC4;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    alu_src_b_o  = ALU_SRC_B_RT;
    alu_op_o     = ALU_OP_ADD;
    rtype_o      = 1'b0;
    reg_write_o  = 1'b0;
    reg_write2_o = 1'b0;
    mem_to_reg_o = 1'b0;
    link_o       = 1'b0;
    illegal_o    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // The read request stays up until memory answers; IR, opcode and
      // PC+4 are all committed in the completing cycle.
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready) begin
          ir_write_o  = 1'b1;
          pc_write_o  = 1'b1;
          alu_src_b_o = ALU_SRC_B_FOUR;
          opcode_d    = opcode;
          state_d     = S_DECODE;
        end
      end

      // Branch target is computed here speculatively for every opcode.
      S_DECODE: begin
        alu_src_b_o = ALU_SRC_B_IMMSH;
        if (cls.is_r)        state_d = S_R_EXEC;
        else if (cls.is_mem) state_d = S_MEM_ADDR;
        else if (cls.is_br)  state_d = S_BRANCH;
        else if (cls.is_j)   state_d = S_JUMP;
        else if (cls.is_imm) state_d = S_I_EXEC;
        else begin
          illegal_o = 1'b1;
          state_d   = S_FETCH;
        end
      end

      // jr finishes here by loading rs into the PC; no register write.
      S_R_EXEC: begin
        alu_op_o = ALU_OP_FUNCT;
        rtype_o  = 1'b1;
        if (jr) begin
          pc_write_o = 1'b1;
          pc_src_o   = PC_SRC_RS;
          state_d    = S_FETCH;
        end else begin
          state_d = S_R_WB;
        end
      end

      S_R_WB: begin
        rtype_o      = 1'b1;
        reg_write_o  = 1'b1;
        reg_write2_o = 1'b1;
        state_d      = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_b_o = ALU_SRC_B_IMM;
        alu_op_o    = ALU_OP_ITYPE;
        state_d     = S_I_WB;
      end

      S_I_WB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_b_o = ALU_SRC_B_IMM;
        state_d     = cls.is_lw ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_BRANCH: begin
        alu_op_o    = ALU_OP_SUB;
        pc_src_o    = PC_SRC_BRANCH;
        branch_eq_o = !cls.is_bne;
        branch_ne_o = cls.is_bne;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_src_o    = PC_SRC_JUMP;
        link_o      = cls.is_jal;
        reg_write_o = cls.is_jal;
        state_d     = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
module tb_multicycle_main_controller;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       br_eq;
    logic       br_ne;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       rtype;
    logic       reg_write;
    logic       reg_write2;
    logic       mem_to_reg;
    logic       link;
    logic       illegal;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       rdy;
    logic       jr;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       jr;
  logic       ir_write_o, pc_write_o, branch_eq_o, branch_ne_o;
  logic [1:0] pc_src_o;
  logic       mem_read_o, mem_write_o, i_or_d_o;
  logic [1:0] alu_src_b_o, alu_op_o;
  logic       rtype_o, reg_write_o, reg_write2_o, mem_to_reg_o, link_o, illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  out_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  multicycle_main_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .jr           (jr),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .branch_eq_o  (branch_eq_o),
    .branch_ne_o  (branch_ne_o),
    .pc_src_o     (pc_src_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .i_or_d_o     (i_or_d_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .rtype_o      (rtype_o),
    .reg_write_o  (reg_write_o),
    .reg_write2_o (reg_write2_o),
    .mem_to_reg_o (mem_to_reg_o),
    .link_o       (link_o),
    .illegal_o    (illegal_o)
  );

  function automatic out_t got_out();
    out_t o;
    o.ir_write   = ir_write_o;
    o.pc_write   = pc_write_o;
    o.br_eq      = branch_eq_o;
    o.br_ne      = branch_ne_o;
    o.pc_src     = pc_src_o;
    o.mem_read   = mem_read_o;
    o.mem_write  = mem_write_o;
    o.i_or_d     = i_or_d_o;
    o.alu_src_b  = alu_src_b_o;
    o.alu_op     = alu_op_o;
    o.rtype      = rtype_o;
    o.reg_write  = reg_write_o;
    o.reg_write2 = reg_write2_o;
    o.mem_to_reg = mem_to_reg_o;
    o.link       = link_o;
    o.illegal    = illegal_o;
    return o;
  endfunction

  // Expected output bundles for each controller state.
  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_fetch(logic rdy);
    out_t o = '0;
    o.mem_read = 1'b1;
    if (rdy) begin
      o.ir_write  = 1'b1;
      o.pc_write  = 1'b1;
      o.alu_src_b = 2'b01;
    end
    return o;
  endfunction
  function automatic out_t o_decode(logic ill);
    out_t o = '0;
    o.alu_src_b = 2'b11;
    o.illegal   = ill;
    return o;
  endfunction
  function automatic out_t o_rexec(logic j);
    out_t o = '0;
    o.alu_op = 2'b10;
    o.rtype  = 1'b1;
    if (j) begin
      o.pc_write = 1'b1;
      o.pc_src   = 2'b11;
    end
    return o;
  endfunction
  function automatic out_t o_rwb();
    out_t o = '0;
    o.rtype = 1'b1; o.reg_write = 1'b1; o.reg_write2 = 1'b1;
    return o;
  endfunction
  function automatic out_t o_iexec();
    out_t o = '0;
    o.alu_src_b = 2'b10; o.alu_op = 2'b11;
    return o;
  endfunction
  function automatic out_t o_iwb();
    out_t o = '0;
    o.reg_write = 1'b1;
    return o;
  endfunction
  function automatic out_t o_memaddr();
    out_t o = '0;
    o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic out_t o_memrd();
    out_t o = '0;
    o.mem_read = 1'b1; o.i_or_d = 1'b1;
    return o;
  endfunction
  function automatic out_t o_memwb();
    out_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
    return o;
  endfunction
  function automatic out_t o_memwr();
    out_t o = '0;
    o.mem_write = 1'b1; o.i_or_d = 1'b1;
    return o;
  endfunction
  function automatic out_t o_branch(logic ne);
    out_t o = '0;
    o.alu_op = 2'b01; o.pc_src = 2'b01;
    o.br_eq = !ne; o.br_ne = ne;
    return o;
  endfunction
  function automatic out_t o_jump(logic jal);
    out_t o = '0;
    o.pc_write = 1'b1; o.pc_src = 2'b10;
    o.link = jal; o.reg_write = jal;
    return o;
  endfunction

  task automatic add_vec(input string nm, input logic [5:0] op, input logic rdy,
                         input logic j, input out_t e);
    vec_t v;
    v.name = nm; v.op = op; v.rdy = rdy; v.jr = j; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string nm, input out_t e);
    out_t g;
    g = got_out();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, g, e);
    end
  endtask

  // Drive one cycle of inputs, queue the expected bundle, compare at the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input string nm, input logic [5:0] op, input logic rdy,
                      input logic j, input out_t e);
    opcode    = op;
    mem_ready = rdy;
    jr        = j;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    check_now(name_q.pop_front(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; jr = 1'b0;

    // add: FETCH, DECODE, R_EXEC, R_WB; jr high in R_WB must be ignored
    add_vec("idle",        6'h00, 1'b1, 1'b1, o_idle());
    add_vec("add_fetch",   6'h00, 1'b1, 1'b1, o_fetch(1'b1));
    add_vec("add_decode",  6'h3f, 1'b1, 1'b1, o_decode(1'b0));
    add_vec("add_rexec",   6'h3f, 1'b1, 1'b0, o_rexec(1'b0));
    add_vec("add_rwb",     6'h3f, 1'b0, 1'b1, o_rwb());
    // jr: R_WB skipped
    add_vec("jr_fetch",    6'h00, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("jr_decode",   6'h23, 1'b0, 1'b0, o_decode(1'b0));
    add_vec("jr_rexec",    6'h23, 1'b0, 1'b1, o_rexec(1'b1));
    // lw with a slow fetch and 3 wait cycles in MEM_RD
    add_vec("lw_fetch_w",  6'h00, 1'b0, 1'b0, o_fetch(1'b0));
    add_vec("lw_fetch",    6'h23, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("lw_decode",   6'h00, 1'b1, 1'b1, o_decode(1'b0));
    add_vec("lw_addr",     6'h00, 1'b1, 1'b1, o_memaddr());
    add_vec("lw_rd_w1",    6'h00, 1'b0, 1'b1, o_memrd());
    add_vec("lw_rd_w2",    6'h00, 1'b0, 1'b0, o_memrd());
    add_vec("lw_rd_w3",    6'h00, 1'b0, 1'b0, o_memrd());
    add_vec("lw_rd",       6'h00, 1'b1, 1'b0, o_memrd());
    add_vec("lw_wb",       6'h00, 1'b0, 1'b0, o_memwb());
    // sw with one wait cycle
    add_vec("sw_fetch",    6'h2b, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("sw_decode",   6'h23, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("sw_addr",     6'h23, 1'b0, 1'b0, o_memaddr());
    add_vec("sw_wr_w",     6'h23, 1'b0, 1'b0, o_memwr());
    add_vec("sw_wr",       6'h23, 1'b1, 1'b0, o_memwr());
    // bne, beq, jal, j
    add_vec("bne_fetch",   6'h05, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("bne_decode",  6'h04, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("bne_branch",  6'h04, 1'b1, 1'b0, o_branch(1'b1));
    add_vec("jal_fetch",   6'h03, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("jal_decode",  6'h02, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("jal_jump",    6'h02, 1'b1, 1'b0, o_jump(1'b1));
    add_vec("beq_fetch",   6'h04, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("beq_decode",  6'h05, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("beq_branch",  6'h05, 1'b1, 1'b0, o_branch(1'b0));
    add_vec("j_fetch",     6'h02, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("j_decode",    6'h03, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("j_jump",      6'h03, 1'b1, 1'b0, o_jump(1'b0));
    // I-type (addi, lui)
    add_vec("addi_fetch",  6'h08, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("addi_decode", 6'h3f, 1'b1, 1'b1, o_decode(1'b0));
    add_vec("addi_exec",   6'h3f, 1'b1, 1'b1, o_iexec());
    add_vec("addi_wb",     6'h3f, 1'b1, 1'b1, o_iwb());
    add_vec("lui_fetch",   6'h0f, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("lui_decode",  6'h00, 1'b1, 1'b0, o_decode(1'b0));
    add_vec("lui_exec",    6'h00, 1'b1, 1'b0, o_iexec());
    add_vec("lui_wb",      6'h00, 1'b1, 1'b0, o_iwb());
    // illegal opcode: single pulse in DECODE, straight back to FETCH
    add_vec("ill_fetch",   6'h3f, 1'b1, 1'b0, o_fetch(1'b1));
    add_vec("ill_decode",  6'h00, 1'b1, 1'b0, o_decode(1'b1));
    add_vec("ill_after",   6'h00, 1'b0, 1'b0, o_fetch(1'b0));
    add_vec("ill_after2",  6'h00, 1'b0, 1'b0, o_fetch(1'b0));

    // Reset state while rst_n is low.
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", o_idle());
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].rdy, vecs[i].jr, vecs[i].exp);

    // Hand sequence: reset asserted mid-MEM_RD abandons the load.
    step("rst_fetch",  6'h23, 1'b1, 1'b0, o_fetch(1'b1));
    step("rst_decode", 6'h00, 1'b0, 1'b0, o_decode(1'b0));
    step("rst_addr",   6'h00, 1'b0, 1'b0, o_memaddr());
    step("rst_memrd",  6'h00, 1'b0, 1'b0, o_memrd());
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("rst_async_zero", o_idle());
    @(posedge clk);
    #1;
    check_now("rst_held_zero", o_idle());
    rst_n = 1'b1;
    step("rst_idle",   6'h00, 1'b1, 1'b0, o_idle());
    step("rst_fetch2", 6'h00, 1'b0, 1'b0, o_fetch(1'b0));
    step("rst_fetch3", 6'h00, 1'b1, 1'b0, o_fetch(1'b1));
    step("rst_decode2",6'h00, 1'b1, 1'b0, o_decode(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
